// File: rtl/scarv_cop_malu_p.sv
// rtl/scarv_cop_malu_p.sv - multi-precision ALU: madd3/msub3/macc2/mmul3/mclmul3/msll/msrl
// Carryless multiply (op 4) is built only when SCARV_COP_MALU_CLMUL_EN is defined.
module scarv_cop_malu_p #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 4
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            malu_ivalid,
    output logic            malu_iready,
    input  logic [2:0]      malu_op,
    input  logic [XLEN-1:0] malu_rs1,
    input  logic [XLEN-1:0] malu_rs2,
    input  logic [XLEN-1:0] malu_rs3,
    output logic            malu_ovalid,
    input  logic            malu_oready,
    output logic [XLEN-1:0] malu_rd_lo,
    output logic [XLEN-1:0] malu_rd_hi,
    output logic            malu_err
);
    localparam int DW    = 2 * XLEN;
    localparam int NSTEP = XLEN / MUL_STEP;
    localparam int CW    = $clog2(NSTEP + 1) + 1;
    localparam int SHW   = $clog2(DW);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MUL = CW'(NSTEP);

    localparam logic [2:0] OP_MADD   = 3'd0;
    localparam logic [2:0] OP_MSUB   = 3'd1;
    localparam logic [2:0] OP_MACC   = 3'd2;
    localparam logic [2:0] OP_MMUL   = 3'd3;
`ifdef SCARV_COP_MALU_CLMUL_EN
    localparam logic [2:0] OP_MCLMUL = 3'd4;
`endif
    localparam logic [2:0] OP_MSLL   = 3'd5;
    localparam logic [2:0] OP_MSRL   = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [2:0]      op_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] rs3_q;
    logic [DW-1:0]   mcand_q;
    logic [XLEN-1:0] mplier_q;
    logic [DW-1:0]   acc_q;
    logic [CW-1:0]   cnt_q;
    logic [DW-1:0]   res_q;
    logic            err_q;

    logic            is_iter;
    logic [CW-1:0]   cnt_last;
    logic            exec_last;
    logic [DW-1:0]   acc_step;
    logic [DW-1:0]   res_d;
    logic            err_d;

    logic [DW-1:0]   ext1;
    logic [DW-1:0]   ext2;
    logic [DW-1:0]   cin;
    logic [DW-1:0]   sh_src;
    logic [SHW-1:0]  sh_amt;
    logic            sh_big;

`ifdef SCARV_COP_MALU_CLMUL_EN
    assign is_iter = (op_q == OP_MMUL) || (op_q == OP_MCLMUL);
`else
    assign is_iter = (op_q == OP_MMUL);
`endif

    // EXEC spends cnt 0..N-1 on work steps and one final cycle latching the result.
    assign cnt_last  = is_iter ? CNT_MUL : CNT_ONE;
    assign exec_last = (cnt_q == cnt_last);

    assign ext1   = {{XLEN{1'b0}}, rs1_q};
    assign ext2   = {{XLEN{1'b0}}, rs2_q};
    assign cin    = {{(DW-1){1'b0}}, rs3_q[0]};
    assign sh_src = {rs2_q, rs1_q};
    assign sh_amt = rs3_q[SHW-1:0];
    assign sh_big = |rs3_q[XLEN-1:SHW];

    // One radix-2^MUL_STEP digit of the multiplier folded into the accumulator.
    always_comb begin
        acc_step = acc_q;
        for (int b = 0; b < MUL_STEP; b++) begin
            if (mplier_q[b]) begin
`ifdef SCARV_COP_MALU_CLMUL_EN
                if (op_q == OP_MCLMUL) begin
                    acc_step = acc_step ^ (mcand_q << b);
                end else begin
                    acc_step = acc_step + (mcand_q << b);
                end
`else
                acc_step = acc_step + (mcand_q << b);
`endif
            end
        end
    end

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (op_q)
            OP_MADD:   res_d = ext1 + ext2 + cin;
            OP_MSUB:   res_d = ext1 - ext2 - cin;
            OP_MACC:   res_d = {rs2_q, rs3_q} + ext1;
            OP_MMUL:   res_d = acc_q;
`ifdef SCARV_COP_MALU_CLMUL_EN
            OP_MCLMUL: res_d = acc_q;
`endif
            OP_MSLL:   res_d = sh_big ? '0 : (sh_src << sh_amt);
            OP_MSRL:   res_d = sh_big ? '0 : (sh_src >> sh_amt);
            default:   err_d = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (malu_ivalid) state_d = S_EXEC;
            S_EXEC:  if (exec_last) state_d = S_DONE;
            S_DONE:  if (malu_oready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            op_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rs3_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (malu_ivalid) begin
                        op_q     <= malu_op;
                        rs1_q    <= malu_rs1;
                        rs2_q    <= malu_rs2;
                        rs3_q    <= malu_rs3;
                        mcand_q  <= {{XLEN{1'b0}}, malu_rs1};
                        mplier_q <= malu_rs2;
                        acc_q    <= {{XLEN{1'b0}}, malu_rs3};
                        cnt_q    <= '0;
                    end
                end
                S_EXEC: begin
                    if (exec_last) begin
                        res_q <= res_d;
                        err_q <= err_d;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                        if (is_iter) begin
                            acc_q    <= acc_step;
                            mcand_q  <= mcand_q << MUL_STEP;
                            mplier_q <= mplier_q >> MUL_STEP;
                        end
                    end
                end
                S_DONE: begin
                    if (malu_oready) begin
                        res_q <= '0;
                        err_q <= 1'b0;
                    end
                end
                default: begin
                    cnt_q <= '0;
                end
            endcase
        end
    end

    assign malu_iready = (state_q == S_IDLE);
    assign malu_ovalid = (state_q == S_DONE);
    assign malu_rd_lo  = malu_ovalid ? res_q[XLEN-1:0]  : '0;
    assign malu_rd_hi  = malu_ovalid ? res_q[DW-1:XLEN] : '0;
    assign malu_err    = malu_ovalid ? err_q : 1'b0;

endmodule

// File: tb/tb_scarv_cop_malu_p.sv
// tb/tb_scarv_cop_malu_p.sv - randomized bench for scarv_cop_malu_p against a behavioural model
module tb_scarv_cop_malu_p;
    localparam int XLEN     = 32;
    localparam int MUL_STEP = 4;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            malu_ivalid;
    logic            malu_iready;
    logic [2:0]      malu_op;
    logic [XLEN-1:0] malu_rs1;
    logic [XLEN-1:0] malu_rs2;
    logic [XLEN-1:0] malu_rs3;
    logic            malu_ovalid;
    logic            malu_oready;
    logic [XLEN-1:0] malu_rd_lo;
    logic [XLEN-1:0] malu_rd_hi;
    logic            malu_err;

    always #5 g_clk = ~g_clk;

    scarv_cop_malu_p #(.XLEN(XLEN), .MUL_STEP(MUL_STEP)) dut (
        .g_clk       (g_clk),
        .g_reset     (g_reset),
        .malu_ivalid (malu_ivalid),
        .malu_iready (malu_iready),
        .malu_op     (malu_op),
        .malu_rs1    (malu_rs1),
        .malu_rs2    (malu_rs2),
        .malu_rs3    (malu_rs3),
        .malu_ovalid (malu_ovalid),
        .malu_oready (malu_oready),
        .malu_rd_lo  (malu_rd_lo),
        .malu_rd_hi  (malu_rd_hi),
        .malu_err    (malu_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_ops = 0;
    int xfers = 0;
    bit chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit clmul_on();
`ifdef SCARV_COP_MALU_CLMUL_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Result straight from the arithmetic definition: {err, hi, lo}.
    function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] c);
        logic [63:0] r;
        logic        e;
        r = 64'd0;
        e = 1'b0;
        case (op)
            3'd0: r = 64'(a) + 64'(b) + 64'(c[0]);
            3'd1: r = 64'(a) - 64'(b) - 64'(c[0]);
            3'd2: r = {b, c} + 64'(a);
            3'd3: r = 64'(a) * 64'(b) + 64'(c);
            3'd4: begin
                if (clmul_on()) begin
                    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (64'(a) << i);
                    r = r ^ 64'(c);
                end else begin
                    e = 1'b1;
                end
            end
            3'd5: r = (c >= 32'd64) ? 64'd0 : ({b, a} << c);
            3'd6: r = (c >= 32'd64) ? 64'd0 : ({b, a} >> c);
            default: e = 1'b1;
        endcase
        return {e, r};
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op == 3'd3 || (op == 3'd4 && clmul_on())) return XLEN / MUL_STEP + 1;
        return 2;
    endfunction

    // Transaction-level model: accepted -> result visible latency(op) edges later -> held until taken.
    bit          m_busy = 0;
    bit          m_done = 0;
    int          m_left = 0;
    logic [64:0] m_exp  = '0;

    always @(posedge g_clk) begin
        if (g_reset) begin
            m_busy = 0;
            m_done = 0;
            m_left = 0;
        end else if (m_done) begin
            if (malu_oready) m_done = 0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                m_done = 1;
            end
        end else if (malu_ivalid) begin
            m_busy = 1;
            m_left = latency(malu_op);
            m_exp  = ref_model(malu_op, malu_rs1, malu_rs2, malu_rs3);
        end
    end

    always @(negedge g_clk) begin
        if (chk_en) begin
            chk("iready", 64'(malu_iready), 64'(!(m_busy || m_done)));
            chk("ovalid", 64'(malu_ovalid), 64'(m_done));
            chk("rd_lo",  64'(malu_rd_lo),  m_done ? 64'(m_exp[31:0])  : 64'd0);
            chk("rd_hi",  64'(malu_rd_hi),  m_done ? 64'(m_exp[63:32]) : 64'd0);
            chk("err",    64'(malu_err),    m_done ? 64'(m_exp[64])    : 64'd0);
            if (malu_ovalid && malu_oready) xfers++;
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input int stall, input bit early,
                          output logic [31:0] lo, output logic [31:0] hi, output logic err,
                          output int lat);
        bit done;
        @(posedge g_clk); #1;
        malu_ivalid = 1'b1;
        malu_op     = op;
        malu_rs1    = a;
        malu_rs2    = b;
        malu_rs3    = c;
        malu_oready = early;
        @(posedge g_clk); #1;
        malu_ivalid = 1'b0;
        malu_op     = 3'($urandom_range(0, 7));
        malu_rs1    = $urandom;
        malu_rs2    = $urandom;
        malu_rs3    = $urandom;
        lat  = 0;
        done = 0;
        lo   = '0;
        hi   = '0;
        err  = 1'b0;
        while (!done && lat < 64) begin
            @(negedge g_clk);
            if (malu_ovalid) begin
                done = 1;
            end else begin
                lat++;
                @(posedge g_clk); #1;
                malu_ivalid = 1'($urandom_range(0, 1));
            end
        end
        if (!done) begin
            chk("ovalid_timeout", 64'(malu_ovalid), 64'd1);
            @(posedge g_clk); #1;
            g_reset = 1'b1;
            @(posedge g_clk); #1;
            g_reset     = 1'b0;
            malu_ivalid = 1'b0;
            malu_oready = 1'b0;
            return;
        end
        lo  = malu_rd_lo;
        hi  = malu_rd_hi;
        err = malu_err;
        if (!early) begin
            for (int s = 0; s < stall; s++) begin
                @(posedge g_clk); #1;
                @(negedge g_clk);
                chk("stall_ovalid", 64'(malu_ovalid), 64'd1);
                chk("stall_rd", {malu_rd_hi, malu_rd_lo}, {hi, lo});
                chk("stall_err", 64'(malu_err), 64'(err));
            end
            @(posedge g_clk); #1;
            malu_oready = 1'b1;
        end
        @(posedge g_clk); #1;
        malu_oready = 1'b0;
        malu_ivalid = 1'b0;
        n_ops++;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] lo, hi;
    logic        err;
    int          lat;

    initial begin
        g_reset     = 1'b1;
        malu_ivalid = 1'b0;
        malu_op     = '0;
        malu_rs1    = '0;
        malu_rs2    = '0;
        malu_rs3    = '0;
        malu_oready = 1'b0;
        @(posedge g_clk); #1;
        chk_en = 1;
        @(negedge g_clk);
        chk("reset_iready", 64'(malu_iready), 64'd1);
        chk("reset_ovalid", 64'(malu_ovalid), 64'd0);
        chk("reset_rd", {malu_rd_hi, malu_rd_lo}, 64'd0);
        chk("reset_err", 64'(malu_err), 64'd0);
        @(posedge g_clk); #1;
        g_reset = 1'b0;

        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, lo, hi, err, lat);
        chk("madd3_lat", 64'(lat), 64'd2);
        chk("madd3_rd", {hi, lo}, 64'h0000_0001_0000_0001);
        chk("madd3_err", 64'(err), 64'd0);

        run_op(3'd1, 32'd0, 32'd1, 32'd0, 1, 0, lo, hi, err, lat);
        chk("msub3_rd", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("msub3_err", 64'(err), 64'd0);

        run_op(3'd2, 32'd1, 32'd0, 32'hFFFF_FFFF, 0, 1, lo, hi, err, lat);
        chk("macc2_rd", {hi, lo}, 64'h0000_0001_0000_0000);

        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, lo, hi, err, lat);
        chk("mmul3_lat", 64'(lat), 64'd9);
        chk("mmul3_rd", {hi, lo}, 64'hFFFF_FFFF_0000_0000);

        run_op(3'd4, 32'd3, 32'd3, 32'd1, 0, 0, lo, hi, err, lat);
`ifdef SCARV_COP_MALU_CLMUL_EN
        chk("mclmul3_lat", 64'(lat), 64'd9);
        chk("mclmul3_rd", {hi, lo}, 64'h0000_0000_0000_0004);
        chk("mclmul3_err", 64'(err), 64'd0);
`else
        chk("mclmul3_lat", 64'(lat), 64'd2);
        chk("mclmul3_rd", {hi, lo}, 64'd0);
        chk("mclmul3_err", 64'(err), 64'd1);
`endif

        run_op(3'd5, 32'h8000_0000, 32'd0, 32'd1, 0, 0, lo, hi, err, lat);
        chk("msll_1_rd", {hi, lo}, 64'h0000_0001_0000_0000);
        run_op(3'd5, 32'h8000_0000, 32'd0, 32'd64, 3, 0, lo, hi, err, lat);
        chk("msll_64_rd", {hi, lo}, 64'd0);
        run_op(3'd6, 32'd0, 32'd1, 32'd1, 0, 0, lo, hi, err, lat);
        chk("msrl_1_rd", {hi, lo}, 64'h0000_0000_8000_0000);

        run_op(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 32'd5, 0, 0, lo, hi, err, lat);
        chk("op7_err", 64'(err), 64'd1);
        chk("op7_rd", {hi, lo}, 64'd0);

        // Reset four edges into a multiply must abort it silently.
        @(posedge g_clk); #1;
        malu_ivalid = 1'b1;
        malu_op     = 3'd3;
        malu_rs1    = 32'hFFFF_FFFF;
        malu_rs2    = 32'hFFFF_FFFF;
        malu_rs3    = 32'hFFFF_FFFF;
        malu_oready = 1'b1;
        @(posedge g_clk); #1;
        malu_ivalid = 1'b0;
        repeat (3) @(posedge g_clk);
        #1 g_reset = 1'b1;
        @(negedge g_clk);
        chk("abort_pre_iready", 64'(malu_iready), 64'd0);
        @(negedge g_clk);
        chk("abort_iready", 64'(malu_iready), 64'd1);
        chk("abort_ovalid", 64'(malu_ovalid), 64'd0);
        @(posedge g_clk); #1;
        g_reset = 1'b0;
        repeat (12) begin
            @(negedge g_clk);
            chk("abort_no_result", 64'(malu_ovalid), 64'd0);
        end
        @(posedge g_clk); #1;
        malu_oready = 1'b0;
        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, lo, hi, err, lat);
        chk("post_abort_madd3", {hi, lo}, 64'h0000_0001_0000_0001);
        chk("post_abort_lat", 64'(lat), 64'd2);

        for (int k = 0; k < 80; k++) begin
            logic [2:0]  op;
            logic [31:0] c;
            op = 3'($urandom_range(0, 7));
            c  = pick();
            if ((op == 3'd5 || op == 3'd6) && $urandom_range(0, 2) != 0) c = $urandom_range(0, 70);
            run_op(op, pick(), pick(), c, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                   lo, hi, err, lat);
        end

        @(posedge g_clk); #1;
        @(negedge g_clk);
        chk("transfer_count", 64'(xfers), 64'(n_ops));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/scarv_cop_malu_p.md
SCARV_COP_MALU_P -- requirements
Module: scarv_cop_malu_p

Interface
REQ-001 SHALL have parameter XLEN, default 32, word width of operands and each result half (32 or 64).
REQ-002 SHALL have parameter MUL_STEP, default 4, multiplier bits retired per cycle; XLEN divisible by MUL_STEP.
REQ-003 SHALL have port g_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port g_reset  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port malu_ivalid  in  1  request valid.
REQ-006 SHALL have port malu_iready  out  1  block can accept a request.
REQ-007 SHALL have port malu_op  in  3  opcode: 0 madd3, 1 msub3, 2 macc2, 3 mmul3, 4 mclmul3, 5 msll, 6 msrl, 7 reserved.
REQ-008 SHALL have ports malu_rs1, malu_rs2, malu_rs3  in  XLEN  source operands.
REQ-009 SHALL have port malu_ovalid  out  1  result valid.
REQ-010 SHALL have port malu_oready  in  1  consumer accepts result.
REQ-011 SHALL have ports malu_rd_lo, malu_rd_hi  out  XLEN  low and high result words.
REQ-012 SHALL have port malu_err  out  1  illegal or disabled opcode; qualified by malu_ovalid.

Function
REQ-013 SHALL implement FSM IDLE -> EXEC -> DONE -> IDLE; malu_iready=1 only in IDLE.
REQ-014 SHALL accept a request on an edge with malu_ivalid && malu_iready, capturing op and operands; inputs may change afterwards.
REQ-015 SHALL ignore malu_ivalid outside IDLE.
REQ-016 SHALL stay in EXEC for N cycles: N=1 for ops 0,1,2,5,6,7; N=XLEN/MUL_STEP for ops 3,4.
REQ-017 SHALL assert malu_ovalid exactly N+1 cycles after the accept edge (DONE state).
REQ-018 SHALL hold malu_ovalid, malu_rd_lo, malu_rd_hi and malu_err stable in DONE until malu_oready=1, then enter IDLE next edge.
REQ-019 SHALL allow malu_oready asserted early; a transfer occurs only on an edge with ovalid && oready.
REQ-020 madd3: {hi,lo} = rs1 + rs2 + rs3[0]; hi in {0,1}.
REQ-021 msub3: {hi,lo} = rs1 - rs2 - rs3[0], modulo 2^(2*XLEN); hi all ones on borrow, else zero.
REQ-022 macc2: {hi,lo} = {rs2,rs3} + rs1, modulo 2^(2*XLEN).
REQ-023 mmul3: {hi,lo} = rs1*rs2 + rs3, unsigned, exact in 2*XLEN bits, via iterative MUL_STEP-bit partial products with running accumulator.
REQ-024 mclmul3: {hi,lo} = carryless product of rs1 and rs2, XOR zero-extended rs3, iterated MUL_STEP bits per cycle.
REQ-025 msll/msrl: {hi,lo} = {rs2,rs1} logically shifted left/right by rs3; shift amount >= 2*XLEN yields zero.
REQ-026 op 7: malu_err=1, hi=lo=0; malu_err=0 for all implemented ops.
REQ-027 SHALL drive malu_rd_lo, malu_rd_hi, malu_err as zero whenever malu_ovalid=0.

Reset
REQ-028 On g_reset=1 SHALL enter IDLE: malu_iready=1, malu_ovalid=0, malu_err=0, result outputs 0, multiplier counter and accumulator 0.
REQ-029 Reset during EXEC or DONE SHALL abort the operation with no result transfer; g_reset overrides a simultaneous accept.

Configuration
REQ-030 With macro SCARV_COP_MALU_CLMUL_EN defined, op 4 SHALL behave per REQ-024.
REQ-031 Without SCARV_COP_MALU_CLMUL_EN, carryless logic SHALL be absent and op 4 SHALL behave as op 7 (N=1, err=1, zero result).

Verification (XLEN=32, MUL_STEP=4)
REQ-032 madd3 rs1=0xFFFFFFFF rs2=1 rs3=1 -> lo=0x00000001, hi=0x00000001, ovalid 2 cycles after accept.
REQ-033 msub3 rs1=0 rs2=1 rs3=0 -> lo=0xFFFFFFFF, hi=0xFFFFFFFF, err=0.
REQ-034 mmul3 rs1=rs2=rs3=0xFFFFFFFF -> lo=0x00000000, hi=0xFFFFFFFF, ovalid 9 cycles after accept; iready=0 throughout.
REQ-035 mclmul3 rs1=3 rs2=3 rs3=1 -> lo=4, hi=0 with macro; without macro -> err=1, lo=hi=0.
REQ-036 msll rs2=0 rs1=0x80000000 rs3=1 -> hi=1, lo=0; rs3=64 -> hi=lo=0; oready held 0 for 3 cycles -> outputs stable, then one transfer.
REQ-037 g_reset pulsed 4 cycles into mmul3 -> next cycle iready=1, ovalid=0, no result ever emitted; following madd3 completes correctly.
